// File: rtl/stream_rr_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin stream arbiter.
package stream_rr_arbiter_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultNumIn     = 4;

    // Wrap to zero at n so non-power-of-two requester counts never index past n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Round-robin winner search: first requester at or after ptr, wrapping once.
module rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumIn      = DefaultNumIn,
    parameter int unsigned NumInWidth = $clog2(NumIn)
) (
    input  logic [NumIn-1:0]      req,
    input  logic [NumInWidth-1:0] ptr,
    output logic [NumInWidth-1:0] win,
    output logic                  any_req
);

    logic [NumIn-1:0]   mask;
    logic [2*NumIn-1:0] dbl;
    int unsigned        pos;

    // Lower half holds requests at or above ptr; the upper half supplies the wrap-around.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NumIn; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
        pos = 0;
        for (int i = 2 * NumIn - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = i;
            end
        end
        win     = (pos >= NumIn) ? NumInWidth'(pos - NumIn) : NumInWidth'(pos);
        any_req = |req;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin fan-in of NumIn valid/ready streams into one registered output beat.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned DataWidth  = DefaultDataWidth,
    parameter int unsigned NumIn      = DefaultNumIn,
    parameter int unsigned NumInWidth = $clog2(NumIn)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumIn-1:0]                 in_valid_i,
    input  logic [NumIn-1:0][DataWidth-1:0]  in_data_i,
    output logic [NumIn-1:0]                 in_ready_o,
    output logic                             out_valid_o,
    output logic [DataWidth-1:0]             out_data_o,
    output logic [NumInWidth-1:0]            out_src_o,
    input  logic                             out_ready_i
);

    logic                  vld_p1;
    logic [DataWidth-1:0]  data_p1;
    logic [NumInWidth-1:0] src_p1;
    logic [NumInWidth-1:0] ptr;
    logic [NumInWidth-1:0] win;
    logic                  any_req;
    logic                  can_acc;
    logic                  xfer;

    rr_pick #(
        .NumIn      (NumIn),
        .NumInWidth (NumInWidth)
    ) u_pick (
        .req     (in_valid_i),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );

    // Stage p0: grant decision; the winner is always valid, so a grant is a transfer.
    always_comb begin
        can_acc    = !vld_p1 || out_ready_i;
        xfer       = rst_ni && can_acc && any_req;
        in_ready_o = '0;
        if (xfer) begin
            in_ready_o[win] = 1'b1;
        end
    end

    // Stage p1: one-entry output register and priority pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data_i[win];
            src_p1  <= win;
            ptr     <= NumInWidth'(wrap_inc(32'(win), NumIn));
        end else if (out_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid_o = vld_p1;
    assign out_data_o  = data_p1;
    assign out_src_o   = src_p1;

endmodule
